// File: rtl/merger_leaf_loader_if.sv
// Run-memory read port and leaf-FIFO write port of merger_leaf_loader.
// The loader side uses the master modport; memory and FIFOs sit on slave.
interface merger_leaf_loader_if #(
  parameter int LEAF_CNT   = 128,
  parameter int ADDR_W     = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  o_mem_rd;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [LEAF_CNT-1:0]   i_fifo_full;
  logic [LEAF_CNT-1:0]   o_fifo_write;
  logic [DATA_WIDTH-1:0] o_fifo_item;

  modport master (
    output o_mem_rd, o_mem_addr, o_fifo_write, o_fifo_item,
    input  i_mem_data, i_fifo_full
  );

  modport slave (
    input  o_mem_rd, o_mem_addr, o_fifo_write, o_fifo_item,
    output i_mem_data, i_fifo_full
  );
endinterface

// File: rtl/merger_leaf_loader.sv
// Loads each leaf's sorted run from run memory into its leaf FIFO, then TERM_CNT zeros.
// Optional stall-cycle counter is enabled by defining LOADER_PERF_CNT_EN.
module merger_leaf_loader #(
  parameter int LEAF_CNT   = 128,
  parameter int LEAF_W     = 7,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_SEQ    = 128,
  parameter int SEQ_W      = 7,
  parameter int TERM_CNT   = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  merger_leaf_loader_if.master bus,
  output logic                 o_busy,
  output logic                 o_done
`ifdef LOADER_PERF_CNT_EN
  ,
  output logic [31:0]          o_stall_cycles
`endif
);

  localparam int IDX_W  = (LEAF_W > 0) ? LEAF_W : 1;
  localparam int ADDR_W = LEAF_W + SEQ_W;
  localparam int TERM_W = $clog2(TERM_CNT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] PH_DATA = 2'd0;
  localparam logic [1:0] PH_TERM = 2'd1;
  localparam logic [1:0] PH_FIN  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [1:0]            phase_q [LEAF_CNT];
  logic [1:0]            phase_d [LEAF_CNT];
  logic [SEQ_W-1:0]      off_q   [LEAF_CNT];
  logic [SEQ_W-1:0]      off_d   [LEAF_CNT];
  logic [TERM_W-1:0]     term_q  [LEAF_CNT];
  logic [TERM_W-1:0]     term_d  [LEAF_CNT];
  logic                  wr_vld_q, wr_is_data_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [DATA_WIDTH-1:0] item_q, fifo_item;
  logic [LEAF_CNT-1:0]   fifo_write;

  logic                  run_en, start_acc, all_fin, gnt_vld, mem_rd;
  logic [LEAF_CNT-1:0]   elig;
  logic [IDX_W-1:0]      gnt_idx, cand;
  logic [IDX_W+SEQ_W-1:0] addr_full;

  // Reset low also silences grants and the write stage in the same cycle.
  assign run_en    = (state_q == ST_RUN) && i_rst_n;
  assign start_acc = (state_q == ST_IDLE) && i_start;

  // The previous-grant mask (wr_idx_q) covers the lag before i_fifo_full reflects a write.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    all_fin = 1'b1;
    elig    = '0;
    for (int k = 0; k < LEAF_CNT; k++) begin
      if (phase_q[k] != PH_FIN) all_fin = 1'b0;
      elig[k] = run_en && (phase_q[k] != PH_FIN) && !bus.i_fifo_full[k] &&
                !(wr_vld_q && (wr_idx_q == IDX_W'(k)));
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= LEAF_CNT; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % LEAF_CNT);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign mem_rd         = gnt_vld && (phase_q[gnt_idx] == PH_DATA);
  assign addr_full      = {gnt_idx, off_q[gnt_idx]};
  assign bus.o_mem_rd   = mem_rd;
  assign bus.o_mem_addr = mem_rd ? addr_full[ADDR_W-1:0] : '0;

  always_comb begin
    for (int k = 0; k < LEAF_CNT; k++) begin
      phase_d[k] = phase_q[k];
      off_d[k]   = off_q[k];
      term_d[k]  = term_q[k];
      if (start_acc) begin
        phase_d[k] = PH_DATA;
        off_d[k]   = '0;
        term_d[k]  = TERM_W'(TERM_CNT);
      end else if (gnt_vld && (gnt_idx == IDX_W'(k))) begin
        if (phase_q[k] == PH_DATA) begin
          off_d[k] = off_q[k] + 1'b1;
          if (off_q[k] == SEQ_W'(LEN_SEQ - 1)) phase_d[k] = PH_TERM;
        end else begin
          term_d[k] = term_q[k] - 1'b1;
          if (term_q[k] == TERM_W'(1)) phase_d[k] = PH_FIN;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_RUN;
      ST_RUN:   if (all_fin) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (start_acc)    ptr_d = IDX_W'(LEAF_CNT - 1);
    else if (gnt_vld) ptr_d = gnt_idx;
  end

  // Write stage: fixed one-cycle latency matches the memory read latency.
  always_comb begin
    fifo_write = '0;
    fifo_item  = item_q;
    if (wr_vld_q && i_rst_n) begin
      fifo_write[wr_idx_q] = 1'b1;
      fifo_item            = wr_is_data_q ? bus.i_mem_data : '0;
    end
  end

  assign bus.o_fifo_write = fifo_write;
  assign bus.o_fifo_item  = fifo_item;
  assign o_busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done           = (state_q == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(LEAF_CNT - 1);
      wr_vld_q     <= 1'b0;
      wr_is_data_q <= 1'b0;
      wr_idx_q     <= '0;
      item_q       <= '0;
      // NOTE: per-leaf state is flop-based control, so it is reset like any register.
      for (int k = 0; k < LEAF_CNT; k++) begin
        phase_q[k] <= PH_DATA;
        off_q[k]   <= '0;
        term_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_vld_q     <= gnt_vld;
      wr_is_data_q <= mem_rd;
      wr_idx_q     <= gnt_idx;
      item_q       <= fifo_item;
      for (int k = 0; k < LEAF_CNT; k++) begin
        phase_q[k] <= phase_d[k];
        off_q[k]   <= off_d[k];
        term_q[k]  <= term_d[k];
      end
    end
  end

`ifdef LOADER_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts RUN cycles with unfinished leaves but no grant; saturates.
  always_comb begin
    stall_d = stall_q;
    if (start_acc) stall_d = '0;
    else if (run_en && !all_fin && !gnt_vld && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_merger_leaf_loader.sv
// Directed bench for merger_leaf_loader: 4 leaves, 8-word runs, 2 terminators, mem[a]=a+1.
module tb_merger_leaf_loader;
  localparam int LEAF_CNT  = 4;
  localparam int LEAF_W    = 2;
  localparam int DW        = 32;
  localparam int LEN_SEQ   = 8;
  localparam int SEQ_W     = 3;
  localparam int TERM_CNT  = 2;
  localparam int ADDR_W    = LEAF_W + SEQ_W;
  localparam int PER_LEAF  = LEN_SEQ + TERM_CNT;
  localparam int PASS_WR   = LEAF_CNT * PER_LEAF;
  localparam int BASIC_LAT = 42;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
`ifdef LOADER_PERF_CNT_EN
  logic [31:0] stall;
`endif

  merger_leaf_loader_if #(.LEAF_CNT(LEAF_CNT), .ADDR_W(ADDR_W), .DATA_WIDTH(DW)) bus ();

  merger_leaf_loader #(
    .LEAF_CNT(LEAF_CNT), .LEAF_W(LEAF_W), .DATA_WIDTH(DW),
    .LEN_SEQ(LEN_SEQ), .SEQ_W(SEQ_W), .TERM_CNT(TERM_CNT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .bus(bus),
    .o_busy(busy),
    .o_done(done)
`ifdef LOADER_PERF_CNT_EN
    ,
    .o_stall_cycles(stall)
`endif
  );

  always #5 clk = ~clk;

  // Run memory: word[a] = a+1, data one cycle after the read strobe.
  always @(posedge clk) if (bus.o_mem_rd) bus.i_mem_data <= DW'(bus.o_mem_addr) + 32'd1;

  logic [DW-1:0] leaf_q [LEAF_CNT][$];
  int wr_log[$];
  int wr_cnt = 0, done_cnt = 0, onehot_err = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if ($countones(bus.o_fifo_write) > 1) onehot_err++;
    for (int k = 0; k < LEAF_CNT; k++)
      if (bus.o_fifo_write[k]) begin
        leaf_q[k].push_back(bus.o_fifo_item);
        wr_log.push_back(k);
        wr_cnt++;
      end
  end

  int n_pass = 0, n_total = 0;
  int cyc_now = 0, t_start = 0, lat = 0;
  int base_sz[LEAF_CNT];
  int base_log = 0, base_wr = 0, base_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic snap();
    for (int k = 0; k < LEAF_CNT; k++) base_sz[k] = leaf_q[k].size();
    base_log  = wr_log.size();
    base_wr   = wr_cnt;
    base_done = done_cnt;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    t_start = cyc_now;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    lat = cyc_now - t_start;
  endtask

  task automatic verify_pass(input string tag, input bit check_rr);
    int bad;
    logic [DW-1:0] exp;
    check({tag, "_total_wr"}, 64'(wr_cnt - base_wr), 64'(PASS_WR));
    for (int k = 0; k < LEAF_CNT; k++) begin
      check($sformatf("%s_leaf%0d_cnt", tag, k), 64'(leaf_q[k].size() - base_sz[k]), 64'(PER_LEAF));
      bad = 0;
      for (int j = 0; j < PER_LEAF; j++) begin
        exp = (j < LEN_SEQ) ? DW'(LEN_SEQ * k + j + 1) : '0;
        if (base_sz[k] + j >= leaf_q[k].size()) bad++;
        else if (leaf_q[k][base_sz[k] + j] !== exp) bad++;
      end
      check($sformatf("%s_leaf%0d_seq_bad", tag, k), 64'(bad), 64'd0);
    end
    if (check_rr) begin
      bad = 0;
      for (int j = 0; j < PASS_WR; j++) begin
        if (base_log + j >= wr_log.size()) bad++;
        else if (wr_log[base_log + j] != j % LEAF_CNT) bad++;
      end
      check({tag, "_rr_order_bad"}, 64'(bad), 64'd0);
    end
  endtask

  initial begin
    int g, viol, hold_base;
`ifdef LOADER_PERF_CNT_EN
    logic [31:0] stall_base;
`endif
    bus.i_fifo_full = '0;
    repeat (3) tick();

    // Reset state
    check("rst_mem_rd", 64'(bus.o_mem_rd), 64'd0);
    check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    check("rst_fifo_write", 64'(bus.o_fifo_write), 64'd0);
    check("rst_fifo_item", 64'(bus.o_fifo_item), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
`ifdef LOADER_PERF_CNT_EN
    check("rst_stall", 64'(stall), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic pass: first grant is leaf 0 (pointer starts at 3), then leaf 1
    snap();
    start_pass();
    check("basic_first_rd", 64'(bus.o_mem_rd), 64'd1);
    check("basic_first_addr", 64'(bus.o_mem_addr), 64'd0);
    check("basic_first_busy", 64'(busy), 64'd1);
    tick();
    check("basic_first_write", 64'(bus.o_fifo_write), 64'b0001);
    check("basic_first_item", 64'(bus.o_fifo_item), 64'd1);
    check("basic_second_addr", 64'(bus.o_mem_addr), 64'd8);
    wait_done("basic");
    check("basic_latency", 64'(lat), 64'(BASIC_LAT));
    check("basic_busy_at_done", 64'(busy), 64'd0);
    tick();
    check("basic_done_one_cycle", 64'(done), 64'd0);
    check("basic_done_cnt", 64'(done_cnt - base_done), 64'd1);
    check("basic_item_holds", 64'(bus.o_fifo_item), 64'd0);
    verify_pass("basic", 1'b1);

    // Backpressure on leaf 2 for 30 cycles
    snap();
    bus.i_fifo_full = 4'b0100;
    start_pass();
    repeat (29) tick();
    check("bp_leaf2_blocked", 64'(leaf_q[2].size() - base_sz[2]), 64'd0);
    check("bp_leaf0_progress", 64'(leaf_q[0].size() - base_sz[0] >= 8), 64'd1);
    bus.i_fifo_full = '0;
    wait_done("bp");
    check("bp_done_delayed", 64'(lat > BASIC_LAT), 64'd1);
    tick();
    verify_pass("bp", 1'b0);

    // All FIFOs full for 10 cycles mid-pass
    snap();
    start_pass();
    repeat (9) tick();
    bus.i_fifo_full = '1;
    hold_base = wr_cnt;
`ifdef LOADER_PERF_CNT_EN
    stall_base = stall;
`endif
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_mem_rd !== 1'b0 || bus.o_fifo_write !== '0) viol++;
    end
    check("full_activity", 64'(viol), 64'd0);
    check("full_no_writes", 64'(wr_cnt - hold_base), 64'd0);
`ifdef LOADER_PERF_CNT_EN
    check("full_stall_delta", 64'(stall - stall_base), 64'd10);
`endif
    bus.i_fifo_full = '0;
    wait_done("full");
    check("full_latency", 64'(lat), 64'(BASIC_LAT + 10));
    tick();
    verify_pass("full", 1'b1);

    // Reset after 12 grants, with i_start asserted alongside reset
    start_pass();
    g = bus.o_mem_rd ? 1 : 0;
    while (g < 12 && cyc_now - t_start < 100) begin
      tick();
      if (bus.o_mem_rd) g++;
    end
    check("rstmid_grants_reached", 64'(g), 64'd12);
    rst_n = 1'b0;
    start = 1'b1;
    hold_base = wr_cnt;
    tick();
    check("rstmid_write_in_rst", 64'(bus.o_fifo_write), 64'd0);
    check("rstmid_rd_in_rst", 64'(bus.o_mem_rd), 64'd0);
    check("rstmid_busy_in_rst", 64'(busy), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rstmid_no_writes", 64'(wr_cnt - hold_base), 64'd0);
    check("rstmid_start_ignored", 64'(busy), 64'd0);
    snap();
    start_pass();
    check("rstmid_restart_addr", 64'(bus.o_mem_addr), 64'd0);
    wait_done("rstmid");
    check("rstmid_latency", 64'(lat), 64'(BASIC_LAT));
    tick();
    verify_pass("rstmid", 1'b1);

    // i_start pulsed during RUN is ignored
    snap();
    start_pass();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start_latency", 64'(lat), 64'(BASIC_LAT));
    repeat (20) tick();
    check("busy_start_done_cnt", 64'(done_cnt - base_done), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);
    verify_pass("busy_start", 1'b1);

    check("onehot_errors", 64'(onehot_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
